spdif_wb_sample_writer: RTL and testbench
=========================================

# spdif_wb_sample_writer

Wishbone classic initiator that takes a valid/ready stream of decoded S/PDIF audio words and writes them into a circular buffer held in the `block_ram` Wishbone responder. It sits between the S/PDIF decoder datapath and the sample RAM. It maintains the write pointer and fill level, and applies backpressure to the stream when the buffer is full. A consumer returns freed slots one word at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 16: stream and Wishbone data width; multiple of 8.
- `SEL_WIDTH`, 2: byte lanes, equal to `DATA_WIDTH/8`.
- `BASE_ADDR`, 32'h0: byte address of buffer slot 0; must be aligned to `SEL_WIDTH`.
- `DEPTH`, 1024: buffer size in words; must be ≥ 2; need not be a power of two.
- `TIMEOUT`, 15: maximum cycles `wb_stb_o` may stay high without an ack; must be ≥ 1.

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `enable_i` in 1: permits new bus cycles.
- `s_valid_i` in 1: stream word valid.
- `s_data_i` in `DATA_WIDTH`: stream word.
- `s_ready_o` out 1: holding register empty.
- `free_i` in 1: one-cycle pulse; the consumer released one word.
- `clr_err_i` in 1: clears `err_o`.
- `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_we_o` out 1: Wishbone cycle, strobe and write enable.
- `wb_sel_o` out `SEL_WIDTH`: byte selects.
- `wb_adr_o` out 32: byte address.
- `wb_dat_o` out `DATA_WIDTH`: write data.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wr_ptr_o` out `$clog2(DEPTH)`: slot index of the next write.
- `level_o` out `$clog2(DEPTH+1)`: words written and not yet freed.
- `full_o` out 1: `level_o == DEPTH`.
- `err_o` out 1: sticky bus-timeout flag.

## Operation
Holding register:
- One entry, with a `hold_valid` flag.
- `s_ready_o = !hold_valid`.
- A word is accepted when `s_valid_i && s_ready_o` is true at a clock edge.

State machine, states IDLE and WRITE:
- **IDLE → WRITE**: when `enable_i && hold_valid && !full_o`. Assert `wb_cyc_o`, `wb_stb_o`, `wb_we_o` and `wb_sel_o` = all ones. Drive `wb_adr_o = BASE_ADDR + wr_ptr*SEL_WIDTH` and `wb_dat_o` = the held word.
- **WRITE, `wb_ack_i` high**:
  - Deassert all strobes at the next edge.
  - Clear `hold_valid`.
  - Set `wr_ptr` to `wr_ptr+1`, or 0 if `wr_ptr == DEPTH-1`.
  - Increment `level`.
  - Return to IDLE.
- **WRITE, no ack**: the timeout counter increments each cycle.
  - When the counter reaches `TIMEOUT` with no ack, abort: drop cyc/stb and go to IDLE.
  - Set `err_o`.
  - Discard the held word (clear `hold_valid`).
  - `wr_ptr` and `level` are unchanged.
- **`enable_i` low**: no new cycle starts. A cycle already in progress runs to ack or timeout.

Level and flags:
- `free_i` decrements `level`. It is ignored when `level == 0`.
- Ack and `free_i` in the same cycle leave `level` unchanged.
- `full_o` blocks the IDLE → WRITE transition only. The holding register may still fill, after which `s_ready_o` falls.
- `clr_err_i` clears `err_o`. If a timeout occurs in the same cycle, the set wins.
- Outputs driven while idle: `wb_dat_o` = held word; `wb_adr_o` = next address; `wb_sel_o` = 0; `wb_we_o` = 0.

## Timing
- All state changes on the rising edge of `wb_clk_i`.
- **Reset values**:
  - `wb_cyc_o`/`wb_stb_o`/`wb_we_o`/`wb_sel_o` = 0.
  - `wb_adr_o` = `BASE_ADDR`; `wb_dat_o` = 0.
  - `wr_ptr_o` = 0; `level_o` = 0; `full_o` = 0; `err_o` = 0.
  - `s_ready_o` = 1 (hold empty); state IDLE.
- **Reset mid-cycle**: strobes are low after the reset edge. The held word is lost and no ack is counted.
- **Latency**:
  - Word accepted at edge N → `wb_stb_o` high during cycle N+1.
  - Same-cycle ack from `block_ram` → `s_ready_o` high again in cycle N+2.
  - Sustained throughput: one word per 2 cycles.
- **Handshake**:
  - `wb_stb_o` and `wb_cyc_o` are always equal.
  - Address, data and select are held stable while stb is high.
  - An ack seen while stb is low is ignored.
- **Timeout**: with no ack, stb is high for exactly `TIMEOUT` cycles. `err_o` rises on the edge that drops stb.
- **No combinational paths** from `wb_ack_i` or `s_valid_i` to any output.

## Structure
- Shared package holds:
  - the state enum (IDLE, WRITE);
  - a function for the pointer width, `$clog2(DEPTH)`, with a minimum of 1;
  - a function for the level width.
- Timeout counter width: `$clog2(TIMEOUT+1)`, local.
- No sub-module: the holding register, FSM and counters live in one module.
- The bench pairs the writer with `block_ram` (`ADDR_WIDTH` ≥ `$clog2(DEPTH)`) and a stall-capable responder model.

## Test plan
- **Basic write**: reset, stream 0x1111, 0x2222, 0x3333 into `block_ram`, `BASE_ADDR`=0 → writes at byte addresses 0, 2, 4; `level_o`=3; `wr_ptr_o`=3; RAM read-back matches.
- **Wrap**: `DEPTH`=5, `BASE_ADDR`=0x100; write 7 words while pulsing `free_i` after each → 6th word at 0x100, 7th at 0x102; `wr_ptr_o`=2; `level_o`=0.
- **Full**: `DEPTH`=4, no frees, stream 6 words → 4 acked, 5th held, `s_ready_o`=0, `full_o`=1; a single `free_i` → 5th written at slot 0.
- **Free plus ack**: `free_i` coinciding with an ack at `level`=2 → `level` stays 2; `free_i` at `level`=0 → stays 0.
- **Timeout**: stalling responder, `TIMEOUT`=15 → stb high for exactly 15 cycles, `err_o`=1, `wr_ptr` unchanged; `clr_err_i` → `err_o`=0.
- **Enable and reset**: `enable_i` low with a word held → no stb; raise `enable_i` → write issues next cycle. Assert `wb_rst_i` while stb is high → all outputs at reset values after one edge.

Source files
------------

// File: rtl/spdif_wb_sample_writer_pkg.sv
// Shared types and width helpers for the S/PDIF Wishbone sample writer.
// Sizes the pointer and level registers from the buffer depth.
package spdif_wb_sample_writer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } writerState_t;

   // A one-slot buffer would give $clog2 == 0, so keep at least one bit.
   function automatic int ptrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int levelWidth(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/spdif_wb_sample_writer.sv
// Wishbone classic initiator that writes decoded S/PDIF words into a circular buffer,
// tracking write pointer and fill level and back-pressuring the stream when full.
module spdif_wb_sample_writer
   import spdif_wb_sample_writer_pkg::*;
#(
   parameter int          DATA_WIDTH = 16,
   parameter int          SEL_WIDTH  = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          DEPTH      = 1024,
   parameter int          TIMEOUT    = 15
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_i,
   input  logic                           enable_i,
   input  logic                           s_valid_i,
   input  logic [DATA_WIDTH-1:0]          s_data_i,
   output logic                           s_ready_o,
   input  logic                           free_i,
   input  logic                           clr_err_i,
   output logic                           wb_cyc_o,
   output logic                           wb_stb_o,
   output logic                           wb_we_o,
   output logic [SEL_WIDTH-1:0]           wb_sel_o,
   output logic [31:0]                    wb_adr_o,
   output logic [DATA_WIDTH-1:0]          wb_dat_o,
   input  logic                           wb_ack_i,
   output logic [ptrWidth(DEPTH)-1:0]     wr_ptr_o,
   output logic [levelWidth(DEPTH)-1:0]   level_o,
   output logic                           full_o,
   output logic                           err_o
);

   localparam int PW = ptrWidth(DEPTH);
   localparam int LW = levelWidth(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

   writerState_t r_state, w_nextState;
   logic                  r_holdValid;
   logic [DATA_WIDTH-1:0] r_holdData;
   logic [PW-1:0]         r_wrPtr;
   logic [LW-1:0]         r_level;
   logic [TW-1:0]         r_toCnt;
   logic                  r_err;

   logic w_accept, w_start, w_ackDone, w_timeout, w_freeOk, w_busy;

   assign w_accept = s_valid_i && !r_holdValid;
   assign w_freeOk = free_i && (r_level != '0);
   assign w_busy   = (r_state == WRITE);

   // A word arriving this edge may start its bus cycle on the same edge,
   // which is what allows one word every two cycles.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_ackDone   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable_i && (r_holdValid || w_accept) && !full_o) begin
               w_nextState = WRITE;
               w_start     = 1'b1;
            end
         end
         WRITE: begin
            if (wb_ack_i) begin
               w_ackDone   = 1'b1;
               w_nextState = IDLE;
            end else if (r_toCnt == TO_LAST) begin
               w_timeout   = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_holdValid <= 1'b0;
         r_holdData  <= '0;
      end else if (w_ackDone || w_timeout) begin
         r_holdValid <= 1'b0;
      end else if (w_accept) begin
         r_holdValid <= 1'b1;
         r_holdData  <= s_data_i;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || w_start || !w_busy) r_toCnt <= '0;
      else if (!wb_ack_i)                 r_toCnt <= r_toCnt + TW'(1);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)       r_wrPtr <= '0;
      else if (w_ackDone) r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
   end

   // A completed write and a release in the same cycle cancel out.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_level <= '0;
      end else begin
         case ({w_ackDone, w_freeOk})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)       r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      else if (clr_err_i) r_err <= 1'b0;
   end

   assign s_ready_o = !r_holdValid;
   assign full_o    = (r_level == FULL_LEVEL);
   assign err_o     = r_err;
   assign wr_ptr_o  = r_wrPtr;
   assign level_o   = r_level;
   assign wb_cyc_o  = w_busy;
   assign wb_stb_o  = w_busy;
   assign wb_we_o   = w_busy;
   assign wb_sel_o  = w_busy ? {SEL_WIDTH{1'b1}} : '0;
   assign wb_adr_o  = BASE_ADDR + 32'(r_wrPtr) * 32'(SEL_WIDTH);
   assign wb_dat_o  = r_holdData;

endmodule

// File: tb/tb_spdif_wb_sample_writer.sv
// Directed bench for the sample writer with a behavioural block RAM responder
// that can stall, and a scoreboard of expected bus writes.
module tb_spdif_wb_sample_writer;

   localparam int          DW    = 16;
   localparam int          SW    = 2;
   localparam logic [31:0] BASE  = 32'h100;
   localparam int          DEPTH = 5;
   localparam int          TO    = 15;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable, sValid, sReady, freeP, clrErr;
   logic [DW-1:0] sData;
   logic          cyc, stb, we, ack, full, err;
   logic [SW-1:0] sel;
   logic [31:0]   adr;
   logic [DW-1:0] dat;
   logic [2:0]    wrPtr;
   logic [2:0]    level;
   logic          stall, forceAck;

   typedef struct {
      logic [31:0]   adr;
      logic [DW-1:0] dat;
   } expWrite_t;

   expWrite_t     expQ[$];
   logic [DW-1:0] mem [0:255];
   logic [31:0]   obsAdr [0:63];
   logic [DW-1:0] obsDat [0:63];
   int            obsCount = 0;
   int            rdIdx, mSlot, checks, failures;

   always #5 clock = ~clock;

   spdif_wb_sample_writer #(
      .DATA_WIDTH(DW), .SEL_WIDTH(SW), .BASE_ADDR(BASE), .DEPTH(DEPTH), .TIMEOUT(TO)
   ) u_dut (
      .wb_clk_i(clock), .wb_rst_i(reset), .enable_i(enable),
      .s_valid_i(sValid), .s_data_i(sData), .s_ready_o(sReady),
      .free_i(freeP), .clr_err_i(clrErr),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
      .wb_adr_o(adr), .wb_dat_o(dat), .wb_ack_i(ack),
      .wr_ptr_o(wrPtr), .level_o(level), .full_o(full), .err_o(err)
   );

   // Block RAM acks in the same cycle unless stalled; forceAck injects stray acks.
   assign ack = (stb && !stall) || forceAck;

   always @(posedge clock) begin
      if (!reset && stb && ack && we) begin
         mem[adr[8:1]]    <= dat;
         obsAdr[obsCount] <= adr;
         obsDat[obsCount] <= dat;
         obsCount         <= obsCount + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic applyReset();
      check("unexpected_writes", obsCount - rdIdx, 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      mSlot = 0;
      rdIdx = obsCount;
      expQ.delete();
   endtask

   // Offers one word, waits for the handshake, and records the write it should cause.
   task automatic applyStimulus(input logic [DW-1:0] d, input bit expectWrite);
      bit ok;
      ok     = 1'b0;
      sValid = 1'b1;
      sData  = d;
      for (int k = 0; k < 40; k++) begin
         if (sReady) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("stream_accept", 32'(ok), 1);
      if (ok && expectWrite) begin
         expQ.push_back('{adr: BASE + 32'(mSlot) * 32'(SW), dat: d});
         mSlot = (mSlot + 1) % DEPTH;
      end
      @(negedge clock);
      sValid = 1'b0;
   endtask

   task automatic checkOutput();
      expWrite_t e;
      int        waited;
      while (expQ.size() > 0) begin
         e      = expQ.pop_front();
         waited = 0;
         while (rdIdx >= obsCount && waited < 50) begin
            @(negedge clock);
            waited++;
         end
         check("write_seen", 32'(rdIdx < obsCount), 1);
         if (rdIdx < obsCount) begin
            check("wb_adr", obsAdr[rdIdx], e.adr);
            check("wb_dat", 32'(obsDat[rdIdx]), 32'(e.dat));
            rdIdx++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int hi;
      checks = 0; failures = 0; rdIdx = 0; mSlot = 0;
      reset = 1'b1; enable = 1'b1; sValid = 1'b0; sData = '0;
      freeP = 1'b0; clrErr = 1'b0; stall = 1'b0; forceAck = 1'b0;
      @(negedge clock);
      applyReset();

      // Reset values
      check("rst_cyc", 32'(cyc), 0);
      check("rst_stb", 32'(stb), 0);
      check("rst_we", 32'(we), 0);
      check("rst_sel", 32'(sel), 0);
      check("rst_adr", adr, BASE);
      check("rst_dat", 32'(dat), 0);
      check("rst_wrptr", 32'(wrPtr), 0);
      check("rst_level", 32'(level), 0);
      check("rst_full", 32'(full), 0);
      check("rst_err", 32'(err), 0);
      check("rst_ready", 32'(sReady), 1);

      // Basic write: three words, strobe the cycle after acceptance
      applyStimulus(16'h1111, 1);
      check("stb_latency", 32'(stb), 1);
      check("cyc_eq_stb", 32'(cyc), 1);
      check("we_in_cycle", 32'(we), 1);
      check("sel_in_cycle", 32'(sel), 32'h3);
      check("adr_first", adr, BASE);
      applyStimulus(16'h2222, 1);
      applyStimulus(16'h3333, 1);
      checkOutput();
      check("basic_level", 32'(level), 3);
      check("basic_wrptr", 32'(wrPtr), 3);
      check("ram_0", 32'(mem[8'h80]), 32'h1111);
      check("ram_1", 32'(mem[8'h81]), 32'h2222);
      check("ram_2", 32'(mem[8'h82]), 32'h3333);

      // Free coinciding with ack, then free at level zero
      freeP = 1'b1; @(negedge clock); freeP = 1'b0;
      check("free_dec", 32'(level), 2);
      applyStimulus(16'h4444, 1);
      freeP = 1'b1; @(negedge clock); freeP = 1'b0;
      checkOutput();
      check("free_ack_level", 32'(level), 2);
      check("free_ack_wrptr", 32'(wrPtr), 4);
      freeP = 1'b1; repeat (2) @(negedge clock); freeP = 1'b0;
      check("drain_level", 32'(level), 0);
      freeP = 1'b1; @(negedge clock); freeP = 1'b0;
      check("free_at_zero", 32'(level), 0);

      // Stray ack while idle must be ignored
      forceAck = 1'b1; @(negedge clock); forceAck = 1'b0;
      check("stray_ack_level", 32'(level), 0);
      check("stray_ack_wrptr", 32'(wrPtr), 4);

      // Wrap: seven words with a free after each
      applyReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(16'hA000 + 16'(i), 1);
         @(negedge clock);
         freeP = 1'b1; @(negedge clock); freeP = 1'b0;
      end
      checkOutput();
      check("wrap_wrptr", 32'(wrPtr), 2);
      check("wrap_level", 32'(level), 0);

      // Full: five words fill the buffer, sixth waits in the holding register
      applyReset();
      for (int i = 0; i < 5; i++) applyStimulus(16'hB000 + 16'(i), 1);
      checkOutput();
      check("full_flag", 32'(full), 1);
      check("full_level", 32'(level), 5);
      check("full_wrptr_wrap", 32'(wrPtr), 0);
      applyStimulus(16'hB005, 1);
      sValid = 1'b1; sData = 16'hB006;
      repeat (4) @(negedge clock);
      check("full_ready_low", 32'(sReady), 0);
      check("full_no_stb", 32'(stb), 0);
      freeP = 1'b1; @(negedge clock); freeP = 1'b0;
      repeat (3) @(negedge clock);
      sValid = 1'b0;
      checkOutput();
      check("refill_level", 32'(level), 5);
      check("refill_wrptr", 32'(wrPtr), 1);
      check("refill_held", 32'(sReady), 0);

      // Timeout: stalled responder keeps stb high for exactly TO cycles
      applyReset();
      stall = 1'b1;
      applyStimulus(16'hC0DE, 0);
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         if (!stb) break;
         hi++;
         @(negedge clock);
      end
      check("timeout_cycles", 32'(hi), TO);
      check("timeout_err", 32'(err), 1);
      check("timeout_wrptr", 32'(wrPtr), 0);
      check("timeout_level", 32'(level), 0);
      check("timeout_discard", 32'(sReady), 1);
      stall = 1'b0;
      clrErr = 1'b1; @(negedge clock); clrErr = 1'b0;
      check("clr_err", 32'(err), 0);

      // Enable gating
      enable = 1'b0;
      applyStimulus(16'hD00D, 1);
      repeat (3) @(negedge clock);
      check("disabled_no_stb", 32'(stb), 0);
      check("disabled_held", 32'(sReady), 0);
      enable = 1'b1;
      @(negedge clock);
      check("enable_stb", 32'(stb), 1);
      checkOutput();
      check("enable_level", 32'(level), 1);

      // Reset while a cycle is stalled on the bus
      stall = 1'b1;
      applyStimulus(16'hE00E, 0);
      check("pre_reset_stb", 32'(stb), 1);
      reset = 1'b1; @(negedge clock);
      check("midrst_stb", 32'(stb), 0);
      check("midrst_cyc", 32'(cyc), 0);
      check("midrst_sel", 32'(sel), 0);
      check("midrst_adr", adr, BASE);
      check("midrst_dat", 32'(dat), 0);
      check("midrst_wrptr", 32'(wrPtr), 0);
      check("midrst_level", 32'(level), 0);
      check("midrst_ready", 32'(sReady), 1);
      reset = 1'b0; stall = 1'b0; mSlot = 0;
      @(negedge clock);
      check("unexpected_writes", obsCount - rdIdx, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
